// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and filters the pins, deframes 11-bit frames,
// strips E0/F0 prefixes and break sequences, and strobes each make code out on en.
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 10000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] char,
  output logic       ext,
  output logic       en,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, clk_f_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state, state_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_n;
  logic [WW-1:0] wd, wd_n;
  logic          ext_pend, ext_pend_n;
  logic          brk_pend, brk_pend_n;
  logic [7:0]    char_n;
  logic          ext_n, en_n, err_n;
  logic          byte_ok;

  // Idle PS/2 bus is high, so synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  // clk_f only follows the synced clock after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      clk_f    <= 1'b1;
      clk_f_d  <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_f_d <= clk_f;
      if (clk_s2 == clk_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f    <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_f_d & ~clk_f;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      par_bit   <= 1'b0;
      wd        <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      char      <= 8'h00;
      ext       <= 1'b0;
      en        <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par_bit   <= par_n;
      wd        <= wd_n;
      ext_pend  <= ext_pend_n;
      brk_pend  <= brk_pend_n;
      char      <= char_n;
      ext       <= ext_n;
      en        <= en_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_n      = par_bit;
    wd_n       = wd;
    ext_pend_n = ext_pend;
    brk_pend_n = brk_pend;
    char_n     = char;
    ext_n      = ext;
    en_n       = 1'b0;
    err_n      = 1'b0;
    byte_ok    = 1'b0;

    if (state == IDLE || fall) begin
      wd_n = '0;
    end else if (wd != WW'(TIMEOUT)) begin
      wd_n = wd + 1'b1;
    end

    case (state)
      IDLE: begin
        if (fall && !dat_s2) begin
          state_n   = DATA;
          bit_cnt_n = 4'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_n   = {dat_s2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = dat_s2;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (dat_s2 && (^{shreg, par_bit})) byte_ok = 1'b1;
          else                               err_n   = 1'b1;
          state_n   = IDLE;
          bit_cnt_n = 4'd0;
        end
      end
      default: state_n = IDLE;
    endcase

    // A stalled frame is abandoned; the partial byte is simply never decoded.
    if (state != IDLE && !fall && wd == WW'(TIMEOUT - 1)) begin
      err_n     = 1'b1;
      state_n   = IDLE;
      bit_cnt_n = 4'd0;
      wd_n      = '0;
    end

    if (err_n) begin
      ext_pend_n = 1'b0;
      brk_pend_n = 1'b0;
    end

    if (byte_ok) begin
      if (shreg == 8'hE0) begin
        ext_pend_n = 1'b1;
      end else if (shreg == 8'hF0) begin
        brk_pend_n = 1'b1;
      end else if (brk_pend) begin
        ext_pend_n = 1'b0;
        brk_pend_n = 1'b0;
      end else if (!ext_pend && (shreg inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
        ext_pend_n = 1'b0;
      end else begin
        char_n     = shreg;
        ext_n      = ext_pend;
        en_n       = 1'b1;
        ext_pend_n = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames on the pins and checks
// strobe counts, decoded codes, latency, timeout and reset behaviour.
module tb_ps2_scancode_rx;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 10000;

  logic       CLOCK_50 = 1'b0;
  logic       rst      = 1'b1;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] char;
  logic       ext, en, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_count = 0, err_count = 0, wide_count = 0, both_count = 0;
  int en_cyc = 0, err_cyc = 0, last_fall_cyc = 0;
  logic en_prev = 1'b0, err_prev = 1'b0;
  int en_base, err_base;

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .char      (char),
    .ext       (ext),
    .en        (en),
    .frame_err (frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Strobe monitor sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (en) begin
      en_count = en_count + 1;
      en_cyc   = cyc;
      if (en_prev) wide_count = wide_count + 1;
    end
    if (frame_err) begin
      err_count = err_count + 1;
      err_cyc   = cyc;
      if (err_prev) wide_count = wide_count + 1;
    end
    if (en && frame_err) both_count = both_count + 1;
    en_prev  = en;
    err_prev = frame_err;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits bits of a frame; flip corrupts the odd parity bit.
  task automatic applyStimulus(input logic [7:0] data, input logic flip, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^data) ^ flip, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLOCK_50);
      PS2_DAT = fr[i];
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    repeat (4 * HALF) @(negedge CLOCK_50);
  endtask

  task automatic markCounts();
    en_base  = en_count;
    err_base = err_count;
  endtask

  initial begin
    repeat (5) @(negedge CLOCK_50);
    checkOutput("reset char", char, 8'h00);
    checkOutput("reset ext", ext, 0);
    checkOutput("reset en", en, 0);
    checkOutput("reset frame_err", frame_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    // Plain make code plus pin-to-strobe latency
    markCounts();
    applyStimulus(8'h1D, 1'b0, 11);
    checkOutput("make en count", en_count - en_base, 1);
    checkOutput("make char", char, 8'h1D);
    checkOutput("make ext", ext, 0);
    checkOutput("make no err", err_count - err_base, 0);
    checkOutput("make latency", en_cyc - last_fall_cyc, 11);

    // Break sequence
    markCounts();
    applyStimulus(8'h1B, 1'b0, 11);
    checkOutput("brk first en", en_count - en_base, 1);
    checkOutput("brk first char", char, 8'h1B);
    applyStimulus(8'hF0, 1'b0, 11);
    applyStimulus(8'h1B, 1'b0, 11);
    checkOutput("brk total en", en_count - en_base, 1);
    checkOutput("brk char held", char, 8'h1B);

    // Pend flags clear after break; typematic repeats each strobe
    markCounts();
    applyStimulus(8'h1D, 1'b0, 11);
    applyStimulus(8'h1D, 1'b0, 11);
    checkOutput("repeat en", en_count - en_base, 2);
    checkOutput("repeat char", char, 8'h1D);
    checkOutput("repeat ext", ext, 0);

    // Extended code, then plain code clears ext
    markCounts();
    applyStimulus(8'hE0, 1'b0, 11);
    checkOutput("E0 alone no en", en_count - en_base, 0);
    applyStimulus(8'h75, 1'b0, 11);
    checkOutput("ext en", en_count - en_base, 1);
    checkOutput("ext char", char, 8'h75);
    checkOutput("ext flag", ext, 1);
    applyStimulus(8'h1D, 1'b0, 11);
    checkOutput("post-ext char", char, 8'h1D);
    checkOutput("post-ext flag", ext, 0);

    // Controller response byte is dropped
    markCounts();
    applyStimulus(8'hFA, 1'b0, 11);
    checkOutput("FA dropped", en_count - en_base, 0);
    checkOutput("FA char held", char, 8'h1D);

    // Parity error, then idle glitches
    markCounts();
    applyStimulus(8'h1D, 1'b1, 11);
    checkOutput("parity err", err_count - err_base, 1);
    checkOutput("parity no en", en_count - en_base, 0);
    checkOutput("parity char held", char, 8'h1D);
    markCounts();
    for (int g = 0; g < 3; g++) begin
      PS2_CLK = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
      repeat (30) @(negedge CLOCK_50);
    end
    checkOutput("glitch no en", en_count - en_base, 0);
    checkOutput("glitch no err", err_count - err_base, 0);

    // Timeout after start + 4 data bits
    markCounts();
    applyStimulus(8'h1B, 1'b0, 5);
    repeat (TIMEOUT + 200) @(negedge CLOCK_50);
    checkOutput("timeout err", err_count - err_base, 1);
    checkOutput("timeout no en", en_count - en_base, 0);
    checkOutput("timeout window",
                ((err_cyc - last_fall_cyc - 11) >= TIMEOUT - 11) &&
                ((err_cyc - last_fall_cyc - 11) <= TIMEOUT + 11), 1);
    markCounts();
    applyStimulus(8'h1B, 1'b0, 11);
    checkOutput("recover en", en_count - en_base, 1);
    checkOutput("recover char", char, 8'h1B);

    // Reset mid-frame
    markCounts();
    applyStimulus(8'h1D, 1'b0, 6);
    @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);
    rst = 1'b0;
    checkOutput("midrst char", char, 8'h00);
    checkOutput("midrst ext", ext, 0);
    repeat (TIMEOUT + 200) @(negedge CLOCK_50);
    checkOutput("midrst no err", err_count - err_base, 0);
    checkOutput("midrst no en", en_count - en_base, 0);
    applyStimulus(8'hAA, 1'b0, 11);
    checkOutput("AA no en", en_count - en_base, 0);
    checkOutput("AA no err", err_count - err_base, 0);
    checkOutput("AA char", char, 8'h00);

    checkOutput("strobe width", wide_count, 0);
    checkOutput("strobe exclusive", both_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
